// File: rtl/dmem_pkg.sv
// Shared types for the handshaked data memory.
// Width encodings, FSM states and width legality check.
package dmem_pkg;

  typedef enum logic [2:0] {
    SB  = 3'b000,
    SH  = 3'b001,
    SW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_width_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Unsigned widths exist only for loads.
  function automatic logic is_legal_width(
    input logic [2:0] width,
    input logic       write
  );
    logic ok;
    ok = 1'b0;
    case (width)
      SB, SH, SW: ok = 1'b1;
      LBU, LHU:   ok = !write;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads and stores.
// Pure combinational: formats load data, merges store data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  bsh;
  logic [4:0]  hsh;

  assign bsh = {addr_lo, 3'b000};
  assign hsh = {addr_lo[1], 4'b0000};
  assign byte_sel = word[bsh +: 8];
  assign half_sel = word[hsh +: 16];

  // Load formatting: pick lane, then sign/zero extend.
  always_comb begin
    ld_data = '0;
    case (width)
      SB:      ld_data = {{24{byte_sel[7]}}, byte_sel};
      SH:      ld_data = {{16{half_sel[15]}}, half_sel};
      SW:      ld_data = word;
      LBU:     ld_data = {24'd0, byte_sel};
      LHU:     ld_data = {16'd0, half_sel};
      default: ld_data = '0;
    endcase
  end

  // Store merge: replace only the addressed lane.
  always_comb begin
    st_word = word;
    case (width)
      SB:      st_word[bsh +: 8]  = wdata[7:0];
      SH:      st_word[hsh +: 16] = wdata[15:0];
      SW:      st_word = wdata;
      default: st_word = word;
    endcase
  end

endmodule

// File: rtl/data_memory_hs.sv
// Handshaked RV32I data memory with fixed-latency response.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word access.
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 200,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] MMIO_ADDR    = 32'h0000_0064
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mmio_out
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q;
  logic [31:0] mmio_q;
  logic        err_q;

  logic          accept;
  logic          in_range;
  logic          misalign;
  logic          err;
  logic          store_ok;
  logic          mmio_hit;
  logic [AW-1:0] widx;
  logic [31:0]   cur_word;
  logic [31:0]   ld_data;
  logic [31:0]   st_word;

  assign in_range = req_addr[31:2] < 30'(DEPTH_WORDS);
  assign widx     = in_range ? req_addr[AW+1:2] : '0;
  assign cur_word = mem[widx];
  assign mmio_hit = req_addr[31:2] == MMIO_ADDR[31:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign =
    ((req_width[1:0] == 2'b01) && req_addr[0]) ||
    ((req_width == SW) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept   = req_valid & req_ready;
  assign err      = !in_range || misalign ||
                    !is_legal_width(req_width, req_write);
  assign store_ok = accept & req_write & ~err;

  dmem_lane_align u_align (
    .word    (cur_word),
    .width   (req_width),
    .addr_lo (req_addr[1:0]),
    .wdata   (req_wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // RAM write at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset_n && store_ok) begin
      mem[widx] <= st_word;
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Response data, error flag and MMIO mirror captured on accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      mmio_q  <= '0;
    end else if (accept) begin
      rdata_q <= (req_write || err) ? 32'd0 : ld_data;
      err_q   <= err;
      if (store_ok && mmio_hit) begin
        mmio_q <= st_word;
      end
    end
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        cnt_d     = '0;
        if (req_valid) begin
          state_d = (READ_LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == 16'(READ_LATENCY - 2)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;
  assign mmio_out  = mmio_q;

endmodule

// File: tb/tb_data_memory_hs.sv
// Self-checking bench for data_memory_hs.
// Random and directed ops against a byte-arithmetic memory model.
module tb_data_memory_hs;

  localparam int DEPTH = 200;
  localparam int LAT   = 3;
  localparam logic [31:0] MMIO = 32'h0000_0064;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_width = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mmio_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] mmio_m = 32'd0;

  typedef struct {
    logic        w;
    logic [2:0]  wd;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
  } op_t;

  always #5 clk = ~clk;

  data_memory_hs #(
    .DEPTH_WORDS  (DEPTH),
    .READ_LATENCY (LAT),
    .MMIO_ADDR    (MMIO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_width (req_width),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .mmio_out  (mmio_out)
  );

  function automatic logic m_err(input logic w, input logic [2:0] wd,
                                 input logic [31:0] a);
    logic e;
    e = ((a / 4) >= DEPTH);
    if (wd == 3'd3 || wd > 3'd5) e = 1'b1;
    if (w && wd >= 3'd4) e = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((wd == 3'd1 || wd == 3'd5) && (a % 2 != 0)) e = 1'b1;
    if (wd == 3'd2 && (a % 4 != 0)) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] wd,
                                         input logic [31:0] a);
    logic [31:0] w, b, h;
    w = mem_m[a / 4];
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (wd)
      3'd0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'd1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'd2: return w;
      3'd4: return b;
      3'd5: return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_merge(input logic [2:0] wd,
                                          input logic [31:0] a,
                                          input logic [31:0] d);
    logic [31:0] w;
    int sb, sh;
    w  = mem_m[a / 4];
    sb = 8 * (a % 4);
    sh = 16 * ((a / 2) % 2);
    case (wd)
      3'd0: return (w & ~(32'hFF << sb)) | ((d & 32'hFF) << sb);
      3'd1: return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      default: return d;
    endcase
  endfunction

  task automatic model(input logic w, input logic [2:0] wd,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
    logic [31:0] mw;
    er = m_err(w, wd, a);
    rd = 32'd0;
    if (!er) begin
      if (w) begin
        mw = m_merge(wd, a, d);
        mem_m[a / 4] = mw;
        if ((a / 4) == (MMIO / 4)) mmio_m = mw;
      end else begin
        rd = m_load(wd, a);
      end
    end
  endtask

  task automatic xact(input logic w, input logic [2:0] wd,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er,
                      output int lat, output logic [31:0] mm);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_width = wd;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    mm = mmio_out;
    req_valid = 1'b0;
    req_addr  = $urandom;
    lat = -1;
    rd  = 32'hx;
    er  = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        rd  = rsp_rdata;
        er  = rsp_error;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 1", req_ready);
    end
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rsp got v=%b e=%b want 0 0",
               rsp_valid, rsp_error);
    end
    n_cmp++;
    if (rsp_rdata !== 32'd0 || mmio_out !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_data got rd=%h mmio=%h want 0 0",
               rsp_rdata, mmio_out);
    end
    reset_n = 1'b1;
    mmio_m = 32'd0;
  endtask

  task automatic test_init;
    logic [31:0] rd, mm, erd, d;
    logic er, eer;
    int lat;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model(1'b1, 3'd2, 32'(i * 4), d, erd, eer);
      xact(1'b1, 3'd2, 32'(i * 4), d, rd, er, lat, mm);
      n_cmp++;
      if (er !== 1'b0 || rd !== 32'd0 || lat != LAT) begin
        n_bad++;
        $display("FAIL init_sw[%0d] got e=%b rd=%h lat=%0d want 0 0 %0d",
                 i, er, rd, lat, LAT);
      end
    end
  endtask

  task automatic test_directed;
    op_t t[$];
    logic [31:0] rd, mm, erd;
    logic er, eer;
    int lat;
    t.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    t.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    t.push_back('{1'b1, 3'd2, 32'h10, 32'h11223344, 32'h0, 1'b0});
    t.push_back('{1'b1, 3'd0, 32'h13, 32'h80, 32'h0, 1'b0});
    t.push_back('{1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0});
    t.push_back('{1'b0, 3'd4, 32'h13, 32'h0, 32'h00000080, 1'b0});
    t.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 32'h80223344, 1'b0});
    t.push_back('{1'b1, 3'd2, 32'h20, 32'h12345678, 32'h0, 1'b0});
    t.push_back('{1'b1, 3'd1, 32'h22, 32'hA5A5, 32'h0, 1'b0});
    t.push_back('{1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFFA5A5, 1'b0});
    t.push_back('{1'b0, 3'd5, 32'h22, 32'h0, 32'h0000A5A5, 1'b0});
    t.push_back('{1'b0, 3'd5, 32'h20, 32'h0, 32'h00005678, 1'b0});
    t.push_back('{1'b1, 3'd2, 32'h64, 32'h000000FF, 32'h0, 1'b0});
    t.push_back('{1'b1, 3'd0, 32'h65, 32'h12, 32'h0, 1'b0});
    t.push_back('{1'b0, 3'd2, 32'h64, 32'h0, 32'h000012FF, 1'b0});
    t.push_back('{1'b0, 3'd2, 32'h320, 32'h0, 32'h0, 1'b1});
    t.push_back('{1'b1, 3'd2, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0});
    t.push_back('{1'b1, 3'd7, 32'h30, 32'h0BADBAD0, 32'h0, 1'b1});
    t.push_back('{1'b1, 3'd4, 32'h30, 32'h0BADBAD0, 32'h0, 1'b1});
    t.push_back('{1'b0, 3'd2, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0});
    foreach (t[i]) begin
      model(t[i].w, t[i].wd, t[i].a, t[i].d, erd, eer);
      xact(t[i].w, t[i].wd, t[i].a, t[i].d, rd, er, lat, mm);
      n_cmp++;
      if (rd !== t[i].rd || er !== t[i].er) begin
        n_bad++;
        $display("FAIL dir[%0d] got rd=%h e=%b want rd=%h e=%b",
                 i, rd, er, t[i].rd, t[i].er);
      end
      n_cmp++;
      if (lat != LAT) begin
        n_bad++;
        $display("FAIL dir_lat[%0d] got %0d want %0d", i, lat, LAT);
      end
      n_cmp++;
      if (mm !== mmio_m) begin
        n_bad++;
        $display("FAIL dir_mmio[%0d] got %h want %h", i, mm, mmio_m);
      end
    end
  endtask

  task automatic test_misalign;
    logic [31:0] rd, mm, erd, want_rd;
    logic er, eer, want_er;
    int lat;
`ifdef DMEM_MISALIGN_TRAP_EN
    want_rd = 32'h0;
    want_er = 1'b1;
`else
    want_rd = 32'h80223344;
    want_er = 1'b0;
`endif
    model(1'b0, 3'd2, 32'h11, 32'h0, erd, eer);
    xact(1'b0, 3'd2, 32'h11, 32'h0, rd, er, lat, mm);
    n_cmp++;
    if (rd !== want_rd || er !== want_er) begin
      n_bad++;
      $display("FAIL misalign_lw got rd=%h e=%b want rd=%h e=%b",
               rd, er, want_rd, want_er);
    end
  endtask

  task automatic test_back_to_back;
    int last, seen;
    last = -1;
    seen = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_width = 3'd2;
    req_addr  = 32'h10;
    for (int cyc = 0; cyc < 60 && seen < 4; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n_cmp++;
        if (rsp_rdata !== 32'h80223344) begin
          n_bad++;
          $display("FAIL b2b_data got %h want 80223344", rsp_rdata);
        end
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != LAT + 1) begin
            n_bad++;
            $display("FAIL b2b_gap got %0d want %0d",
                     cyc - last, LAT + 1);
          end
        end
        last = cyc;
        seen++;
        if (seen == 4) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (seen != 4) begin
      n_bad++;
      $display("FAIL b2b_count got %0d want 4", seen);
    end
  endtask

  task automatic test_reset_wait;
    logic [31:0] d, rd, mm, erd;
    logic er, eer, seen;
    int lat;
    d = $urandom;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_width = 3'd2;
    req_addr  = 32'hA0;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_m[40] = d;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mmio_m = 32'd0;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wait got ready=%b v=%b want 1 0",
               req_ready, rsp_valid);
    end
    n_cmp++;
    if (mmio_out !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_wait_mmio got %h want 0", mmio_out);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wait_norsp got %b want 0", seen);
    end
    model(1'b0, 3'd2, 32'hA0, 32'h0, erd, eer);
    xact(1'b0, 3'd2, 32'hA0, 32'h0, rd, er, lat, mm);
    n_cmp++;
    if (rd !== d || er !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_commit got rd=%h e=%b want rd=%h e=0",
               rd, er, d);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, d, rd, mm, erd;
    logic [2:0] wd;
    logic w, er, eer;
    int lat, sel;
    for (int i = 0; i < 150; i++) begin
      w   = 1'($urandom_range(0, 1));
      wd  = 3'($urandom_range(0, 7));
      d   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)
        a = 32'(4 * DEPTH) + $urandom_range(0, 4000);
      else if (sel < 3)
        a = MMIO + 32'($urandom_range(0, 3));
      else
        a = 32'($urandom_range(0, 4 * DEPTH - 1));
      model(w, wd, a, d, erd, eer);
      xact(w, wd, a, d, rd, er, lat, mm);
      n_cmp++;
      if (rd !== erd || er !== eer || lat != LAT) begin
        n_bad++;
        $display("FAIL rnd[%0d] w=%b wd=%0d a=%h got rd=%h e=%b lat=%0d want rd=%h e=%b lat=%0d",
                 i, w, wd, a, rd, er, lat, erd, eer, LAT);
      end
      n_cmp++;
      if (mm !== mmio_m) begin
        n_bad++;
        $display("FAIL rnd_mmio[%0d] got %h want %h", i, mm, mmio_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_misalign();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
